aes_key_expander: RTL and testbench

// Runtime-selectable AES-128/192/256 key expansion: one 32-bit schedule word per cycle, all words held in
// an internal register file. Start/done handshake; registered read port returns any 128-bit round key.

---
 rtl/aes_key_expander_pkg.sv | 58 +++++
 rtl/aes_key_expander_if.sv | 32 +++
 rtl/aes_key_expander_sbox.sv | 31 +++
 rtl/aes_key_expander.sv | 129 ++++++++++++
 tb/tb_aes_key_expander.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_expander_pkg.sv
// Shared definitions for the AES key expander.
// Contents: schedule geometry constants, key-length encodings, FSM state
// type, and helpers mapping key_len to Nk/Nr and round index to RCON byte.
package aes_key_expander_pkg;

  localparam int NB     = 4;    // words per round key
  localparam int KEY_W  = 256;  // key input width, shorter keys MSB-aligned
  localparam int NW_MAX = 60;   // NB*(14+1) schedule words

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10,
    KL_BAD = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXPAND = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  // Words in the cipher key (Nk)
  function automatic logic [3:0] nk_of(input logic [1:0] key_len);
    case (key_len)
      KL_128:  nk_of = 4'd4;
      KL_192:  nk_of = 4'd6;
      default: nk_of = 4'd8;
    endcase
  endfunction

  // Number of rounds (Nr)
  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      KL_128:  nr_of = 4'd10;
      KL_192:  nr_of = 4'd12;
      default: nr_of = 4'd14;
    endcase
  endfunction

  // Round constant byte, RCON[1..10]
  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon_of = 8'h01;
      4'd2:    rcon_of = 8'h02;
      4'd3:    rcon_of = 8'h04;
      4'd4:    rcon_of = 8'h08;
      4'd5:    rcon_of = 8'h10;
      4'd6:    rcon_of = 8'h20;
      4'd7:    rcon_of = 8'h40;
      4'd8:    rcon_of = 8'h80;
      4'd9:    rcon_of = 8'h1b;
      4'd10:   rcon_of = 8'h36;
      default: rcon_of = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Control/read bus of the AES key expander.
// Handshake: the master raises start for one or more cycles with key_len/key
// stable; the expander only samples start while idle. busy is high during
// expansion, done pulses for one cycle when the last word is written, and
// keys_valid is a level that stays high until the next accepted start or
// reset. err pulses one cycle when start arrives with key_len=11. The read
// port is independent: rk_out reflects rk_idx one cycle later.
// Modports: master = key/round-key consumer, slave = the expander.
interface aes_key_expander_if;
  import aes_key_expander_pkg::*;

  logic             start;
  logic [1:0]       key_len;
  logic [KEY_W-1:0] key;
  logic             busy;
  logic             done;
  logic             keys_valid;
  logic             err;
  logic [3:0]       rk_idx;
  logic [127:0]     rk_out;
  state_e           state_dbg;

  modport master (
    output start, key_len, key, rk_idx,
    input  busy, done, keys_valid, err, rk_out, state_dbg
  );

  modport slave (
    input  start, key_len, key, rk_idx,
    output busy, done, keys_valid, err, rk_out, state_dbg
  );
endinterface

// File: rtl/aes_key_expander_sbox.sv
// AES forward S-box, purely combinational.
// Ports: in_byte (8) -> out_byte (8).
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0x00 sits in the top byte; entry x lives at bits [8*(255-x) +: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // ~in_byte == 255 - in_byte
  assign out_byte = SBOX_TBL[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expander.sv
// AES-128/192/256 key expander: one schedule word per cycle into a 60-word
// register file, plus a registered 128-bit round-key read port.
// Ports: clk, rst (sync, active-high), bus (slave modport: start, key_len,
// key, busy, done, keys_valid, err, rk_idx, rk_out, state_dbg).
module aes_key_expander
  import aes_key_expander_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  aes_key_expander_if.slave   bus
);

  state_e       state, state_nx;
  logic [31:0]  w [NW_MAX];
  logic [5:0]   i;          // index of word being written
  logic [2:0]   j;          // i mod Nk, kept as a wrapping counter
  logic [3:0]   rcon_idx;
  logic [3:0]   nk, nr;
  logic         keys_valid_q, err_q;
  logic [127:0] rk_q;

  logic [3:0]   key_nk, key_nr;
  logic [5:0]   last_i;
  logic [31:0]  w_prev, w_old, sub_in, sub_out, t_word, w_new;
  logic         rk_oob;
  logic [5:0]   rd_base;

  assign key_nk = nk_of(bus.key_len);
  assign key_nr = nr_of(bus.key_len);
  assign last_i = {nr, 2'b11};  // NB*(Nr+1)-1

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (bus.start && (bus.key_len != KL_BAD)) state_nx = ST_EXPAND;
      ST_EXPAND: if (i == last_i) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // ---------------- schedule datapath ----------------
  // i >= nk always holds because i and nk are loaded together.
  assign w_prev = w[i - 6'd1];
  assign w_old  = w[i - {2'b00, nk}];

  // The four S-boxes serve both SubWord(RotWord()) and the 256-bit SubWord.
  assign sub_in = (j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*b +: 8]),
      .out_byte (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    t_word = w_prev;
    if (j == 3'd0)
      t_word = sub_out ^ {rcon_of(rcon_idx), 24'h000000};
    else if ((nk == 4'd8) && (j == 3'd4))
      t_word = sub_out;
  end

  assign w_new = w_old ^ t_word;

  // Out-of-range round keys read as zero; base forced to 0 to stay in bounds.
  assign rk_oob  = (bus.rk_idx > nr);
  assign rd_base = rk_oob ? 6'd0 : {bus.rk_idx, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      i            <= 6'd4;
      j            <= 3'd0;
      rcon_idx     <= 4'd1;
      nk           <= 4'd4;
      nr           <= 4'd10;
      keys_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rk_q         <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.key_len == KL_BAD) begin
              err_q <= 1'b1;
            end else begin
              nk           <= key_nk;
              nr           <= key_nr;
              i            <= {2'b00, key_nk};
              j            <= 3'd0;
              rcon_idx     <= 4'd1;
              keys_valid_q <= 1'b0;
              for (int k = 0; k < 8; k++) begin
                if (4'(k) < key_nk) w[k] <= bus.key[KEY_W-1-32*k -: 32];
              end
            end
          end
        end
        ST_EXPAND: begin
          w[i] <= w_new;
          if (i != last_i) i <= i + 6'd1;
          j <= ({1'b0, j} == nk - 4'd1) ? 3'd0 : j + 3'd1;
          if (j == 3'd0) rcon_idx <= rcon_idx + 4'd1;
        end
        ST_DONE: keys_valid_q <= 1'b1;
        default: ;
      endcase

      rk_q <= rk_oob ? '0 :
              {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
    end
  end

  assign bus.busy       = (state == ST_EXPAND);
  assign bus.done       = (state == ST_DONE);
  assign bus.keys_valid = keys_valid_q;
  assign bus.err        = err_q;
  assign bus.rk_out     = rk_q;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: known-answer table, error,
// reset-abort and start-while-busy sequences, and randomized keys checked
// against a behavioural key-schedule model built from GF(2^8) arithmetic.
module tb_aes_key_expander;
  import aes_key_expander_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_key_expander_if bus();

  aes_key_expander dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [127:0] exp_q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  sb [256];
  logic [31:0] ref_w [60];
  int          ref_nk, ref_nr;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Multiplicative inverse by search, then the FIPS-197 affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int c = 1; c < 256; c++)
      if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic ref_expand(input logic [1:0] kl, input logic [255:0] key);
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    ref_nk = 4 + 2 * int'(kl);
    ref_nr = ref_nk + 6;
    for (int n = 0; n < ref_nk; n++) ref_w[n] = key[255 - 32*n -: 32];
    for (int n = ref_nk; n < 4 * (ref_nr + 1); n++) begin
      temp = ref_w[n-1];
      if (n % ref_nk == 0) begin
        temp = subword({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (ref_nk == 8 && n % ref_nk == 4) begin
        temp = subword(temp);
      end
      ref_w[n] = ref_w[n-ref_nk] ^ temp;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic [1:0] kl, input logic [255:0] key);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.key_len = kl;
    bus.key     = key;
    @(posedge clk);
  endtask

  // Counts negedges after the start edge until done is seen (or -1).
  task automatic wait_done(input string name, output int lat);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 1) check({name, "_busy"}, 128'(bus.busy), 128'd1);
      if (bus.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_expand(input string name, input logic [1:0] kl,
                            input logic [255:0] key, input int exp_lat);
    int lat;
    drive_start(kl, key);
    wait_done(name, lat);
    check({name, "_latency"}, 128'(lat), 128'(exp_lat));
    check({name, "_kv_during_done"}, 128'(bus.keys_valid), 128'd0);
    @(negedge clk);
    check({name, "_done_pulse"}, 128'(bus.done), 128'd0);
    check({name, "_keys_valid"}, 128'(bus.keys_valid), 128'd1);
  endtask

  task automatic check_rk(input string name, input logic [3:0] idx, input logic [127:0] exp);
    logic [127:0] got;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.rk_idx = idx;
    @(negedge clk);
    got = bus.rk_out;
    check(name, got, exp_q.pop_front());
  endtask

  // ---------------- known-answer table ----------------
  typedef struct {
    logic [1:0]   kl;
    logic [255:0] key;
    logic [3:0]   idx;
    logic [127:0] exp_rk;
    int           exp_lat;
  } vec_t;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  vec_t tbl[4];

  initial begin
    int lat;
    int done_seen;
    logic [1:0]   kl;
    logic [255:0] rkey;
    logic [127:0] exp_rk;

    for (int n = 0; n < 256; n++) sb[n] = sbox_calc(8'(n));

    tbl[0] = '{2'd0, K128, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 41};
    tbl[1] = '{2'd0, K128, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 41};
    tbl[2] = '{2'd1, K192, 4'd12, 128'he98ba06f448c773c8ecc720401002202, 47};
    tbl[3] = '{2'd2, K256, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 53};

    // reset state
    rst = 1'b1;
    bus.start = 1'b0; bus.key_len = 2'd0; bus.key = '0; bus.rk_idx = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_kv",   128'(bus.keys_valid), 128'd0);
    check("rst_err",  128'(bus.err), 128'd0);
    check("rst_rk",   bus.rk_out, 128'd0);
    check("rst_state", 128'(bus.state_dbg), 128'(ST_IDLE));
    rst = 1'b0;

    // known-answer vectors
    for (int v = 0; v < 4; v++) begin
      run_expand($sformatf("kat%0d", v), tbl[v].kl, tbl[v].key, tbl[v].exp_lat);
      check_rk($sformatf("kat%0d_rk", v), tbl[v].idx, tbl[v].exp_rk);
    end

    // illegal key length: err pulse, keys_valid untouched
    @(negedge clk);
    bus.start = 1'b1; bus.key_len = 2'b11;
    @(negedge clk);
    bus.start = 1'b0;
    check("bad_err",  128'(bus.err), 128'd1);
    check("bad_busy", 128'(bus.busy), 128'd0);
    @(negedge clk);
    check("bad_err_pulse", 128'(bus.err), 128'd0);
    check("bad_kv",   128'(bus.keys_valid), 128'd1);
    check("bad_busy2", 128'(bus.busy), 128'd0);
    check_rk("rk_idx15", 4'd15, 128'd0);

    // reset in the middle of a 256-bit expansion
    drive_start(2'd2, K256);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 128'(bus.busy), 128'd0);
    check("abort_kv",   128'(bus.keys_valid), 128'd0);
    check("abort_done", 128'(bus.done), 128'd0);
    rst = 1'b0;
    done_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("abort_no_done", 128'(done_seen), 128'd0);
    run_expand("rerun128", tbl[0].kl, tbl[0].key, tbl[0].exp_lat);
    check_rk("rerun128_rk", tbl[0].idx, tbl[0].exp_rk);

    // start pulse with a different key during expansion is ignored
    drive_start(2'd0, K128);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 5) begin
        bus.start = 1'b1; bus.key_len = 2'd2; bus.key = K256;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    check("busy_start_latency", 128'(lat), 128'd41);
    check_rk("busy_start_rk10", 4'd10, tbl[0].exp_rk);
    check_rk("busy_start_rk0",  4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // randomized keys against the reference model
    for (int r = 0; r < 6; r++) begin
      kl = 2'($urandom_range(0, 2));
      for (int n = 0; n < 8; n++) rkey[32*n +: 32] = $urandom;
      ref_expand(kl, rkey);
      run_expand($sformatf("rnd%0d", r), kl, rkey, 4 * (ref_nr + 1) - ref_nk + 1);
      for (int idx = 0; idx < 16; idx++) begin
        exp_rk = (idx <= ref_nr) ?
                 {ref_w[4*idx], ref_w[4*idx+1], ref_w[4*idx+2], ref_w[4*idx+3]} : 128'd0;
        check_rk($sformatf("rnd%0d_rk%0d", r, idx), 4'(idx), exp_rk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
